wb_writer: RTL

- Write-back end of the core pipeline: takes the instruction and ALU result leaving the EXE stage and performs register-file writes.
- This is the write side of the register file, which ID otherwise only reads.
- Holds pending writes in a small in-order queue, because the RF write port can refuse a write in any cycle.
- Back-pressures EXE when the queue is full.
- Optionally provides forwarding of pending results to the register-read stage.

---
 rtl/wb_writer.sv | 118 +++++++++++
 1 files changed

// File: rtl/wb_writer.sv
// Write-back stage: in-order queue of pending register-file writes with RF handshake.
// Define WB_WRITER_FWD_EN to enable forwarding of pending results to the read stage.
module wb_writer #(
  parameter int unsigned RFW = 5,
  parameter int unsigned DW  = 32,
  parameter int unsigned IW  = 32,
  parameter int unsigned QAW = 1
) (
  input  logic           clk,
  input  logic           start,
  input  logic           in_valid,
  input  logic [IW-1:0]  in_inst,
  input  logic [DW-1:0]  in_data,
  output logic           in_ready,
  output logic           rf_we,
  output logic [RFW-1:0] rf_waddr,
  output logic [DW-1:0]  rf_wdata,
  input  logic           rf_ack,
  output logic [QAW:0]   occ,
  input  logic [RFW-1:0] fwd_addrA,
  input  logic [RFW-1:0] fwd_addrB,
  output logic           fwd_hitA,
  output logic           fwd_hitB,
  output logic [DW-1:0]  fwd_dataA,
  output logic [DW-1:0]  fwd_dataB
);

  localparam int unsigned QD = 1 << QAW;
  localparam logic [QAW:0] QdOcc = QD[QAW:0];

  logic [5:0]     opcode;
  logic [RFW-1:0] rd;
  logic           is_wr, push, pop;

  logic [QAW-1:0] head_q, head_d, tail_q, tail_d;
  logic [QAW:0]   occ_q, occ_d;
  logic [RFW-1:0] rd_mem   [QD];
  logic [DW-1:0]  data_mem [QD];

  assign opcode = in_inst[IW-1 -: 6];
  assign rd     = in_inst[IW-7 -: RFW];
  assign is_wr  = (opcode != '0) && (rd != '0);

  logic unused_inst;
  assign unused_inst = ^in_inst[IW-7-RFW:0];

  // Ready looks only at stored occupancy; a same-cycle pop never frees a full queue.
  assign in_ready = !start && (occ_q != QdOcc);
  assign push     = in_valid && in_ready && is_wr;
  assign rf_we    = (occ_q != '0);
  assign pop      = rf_we && rf_ack;
  assign occ      = occ_q;

  // Entry storage is never cleared, so the write outputs are masked while empty.
  assign rf_waddr = rf_we ? rd_mem[head_q]   : '0;
  assign rf_wdata = rf_we ? data_mem[head_q] : '0;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push) tail_d = tail_q + QAW'(1);
    if (pop)  head_d = head_q + QAW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_q]   <= rd;
      data_mem[tail_q] <= in_data;
    end
  end

`ifdef WB_WRITER_FWD_EN
  // Walk oldest to newest so the newest matching entry is the one that sticks.
  function automatic logic [DW:0] fwd_lookup(input logic [RFW-1:0] addr);
    logic [DW:0]    res;
    logic [QAW-1:0] idx;
    res = '0;
    for (int i = 0; i < int'(QD); i++) begin
      idx = head_q + QAW'(i);
      if ((addr != '0) && ((QAW+1)'(i) < occ_q) && (rd_mem[idx] == addr)) begin
        res = {1'b1, data_mem[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {fwd_hitA, fwd_dataA} = fwd_lookup(fwd_addrA);
    {fwd_hitB, fwd_dataB} = fwd_lookup(fwd_addrB);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addrA, fwd_addrB};
  assign fwd_hitA   = 1'b0;
  assign fwd_hitB   = 1'b0;
  assign fwd_dataA  = '0;
  assign fwd_dataB  = '0;
`endif

endmodule
